// File: rtl/aes_round_engine.sv
// Iterative AES-256 encryption datapath: one cipher round per clock over round keys
// supplied by the key-expansion stage, with valid/ready handshakes on both sides.

module AesSubWord (
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (zero maps to zero), then the AES affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] pw;
      inv = 8'h01;
      pw  = x;
      for (int i = 1; i < 8; i++) begin
         pw  = gfMul(pw, pw);
         inv = gfMul(inv, pw);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                    sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

module aes_round_engine #(
   parameter int NR = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NR:0][127:0]  round_keys,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        plain_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        cipher_out
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   state_t       r_state;
   state_t       w_nextState;
   logic [3:0]   r_round;
   logic [127:0] r_data;
   logic [127:0] w_subBytes;
   logic [127:0] w_shifted;
   logic [127:0] w_mixed;
   logic [127:0] w_roundOut;
   logic         w_accept;
   logic         w_step;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mixColumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte (row r, column c) lives at index 4c+r; row r rotates left by r columns.
   function automatic logic [127:0] shiftRows(input logic [127:0] s);
      logic [127:0] t;
      t = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      return t;
   endfunction

   function automatic logic [127:0] mixColumns(input logic [127:0] s);
      logic [127:0] t;
      t = '0;
      for (int c = 0; c < 4; c++) begin
         t[127 - 32*c -: 32] = mixColumn(s[127 - 32*c -: 32]);
      end
      return t;
   endfunction

   for (genvar gc = 0; gc < 4; gc++) begin : g_subWord
      AesSubWord u_subWord (
         .i_word (r_data[127 - 32*gc -: 32]),
         .o_word (w_subBytes[127 - 32*gc -: 32])
      );
   end

   assign w_shifted  = shiftRows(w_subBytes);
   assign w_mixed    = mixColumns(w_shifted);
   // The final round skips MixColumns.
   assign w_roundOut = ((r_round == LAST_ROUND) ? w_shifted : w_mixed) ^ round_keys[r_round];
   assign cipher_out = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_nextState = ROUND;
            end
         end
         ROUND: begin
            w_step = 1'b1;
            if (r_round == LAST_ROUND) w_nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_round <= '0;
      end else if (w_accept) begin
         r_data  <= plain_in ^ round_keys[0];
         r_round <= 4'd1;
      end else if (w_step) begin
         r_data  <= w_roundOut;
         r_round <= r_round + 4'd1;
      end
   end

endmodule
